// File: rtl/key_decoder.sv
// key_decoder: turns PS/2 scan-code set 2 bytes into held-key levels for
// Space, Left arrow and Right arrow. Understands the F0 break prefix and
// the E0 extended prefix. A prefix that is not followed by another byte
// within TIMEOUT_CLKS clocks is dropped.
module key_decoder #(
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right
);

  localparam int CW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          space_q, space_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          timeout_hit;

  // A prefix expires only when no byte arrives on the deadline cycle;
  // a byte on that very cycle is decoded as normal.
  assign timeout_hit = (state_q != IDLE) && (cnt_q == TMO_LAST) && !rx_valid;

  // State register and registered key levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Next-state decode of prefix bytes
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SC_BRK)      state_d = BRK;
          else if (rx_data == SC_EXT) state_d = EXT;
          else                        state_d = IDLE;
        end
        BRK: state_d = IDLE;
        EXT: begin
          if (rx_data == SC_BRK)      state_d = EXT_BRK;
          else if (rx_data == SC_EXT) state_d = EXT;
          else                        state_d = IDLE;
        end
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // Key level updates on the final byte of a make/break sequence
  always_comb begin
    space_d = space_q;
    left_d  = left_q;
    right_d = right_q;
    if (rx_valid) begin
      case (state_q)
        IDLE:    if (rx_data == SC_SPACE) space_d = 1'b1;
        BRK:     if (rx_data == SC_SPACE) space_d = 1'b0;
        EXT: begin
          if (rx_data == SC_LEFT)  left_d  = 1'b1;
          if (rx_data == SC_RIGHT) right_d = 1'b1;
        end
        EXT_BRK: begin
          if (rx_data == SC_LEFT)  left_d  = 1'b0;
          if (rx_data == SC_RIGHT) right_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Prefix age: cleared by any byte or expiry, counts while mid-sequence,
  // saturates rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (rx_valid || timeout_hit)            cnt_d = '0;
    else if (state_q == IDLE)               cnt_d = '0;
    else if (cnt_q != {CW{1'b1}})           cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign key_space = space_q;
  assign key_left  = left_q;
  assign key_right = right_q;

endmodule
